// File: rtl/scale_window_fetch_if.sv
// scale_window_fetch_if
//   Bundles the two handshakes of the scaling feeder: the source frame
//   memory read port and the 2x2 window hand-off to the scaling processor.
//
//   Memory port : mem_rd_en, mem_addr (feeder -> memory), mem_rdata (memory -> feeder,
//                 valid one cycle after mem_rd_en)
//   Window port : imgmn, imgm1n, imgmn1, imgm1n1, loc_x, loc_y, img_rdy
//                 (feeder -> processor), pixel_done (processor -> feeder)
//
//   master : the feeder side (scale_window_fetch)
//   slave  : the environment side (memory + scaling processor)
interface scale_window_fetch_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] imgmn;
    logic [DW-1:0] imgm1n;
    logic [DW-1:0] imgmn1;
    logic [DW-1:0] imgm1n1;
    logic [15:0]   loc_x;
    logic [15:0]   loc_y;
    logic          img_rdy;
    logic          pixel_done;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output imgmn, imgm1n, imgmn1, imgm1n1, loc_x, loc_y, img_rdy,
        input  pixel_done
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  imgmn, imgm1n, imgmn1, imgm1n1, loc_x, loc_y, img_rdy,
        output pixel_done
    );
endinterface

// File: rtl/scale_window_fetch.sv
// scale_window_fetch
//   Source-side feeder for the image-scaling datapath. Walks the target image
//   in raster order, maps each target pixel to a Q8.8 source location, reads
//   the clamped 2x2 source neighbourhood and hands it to the scaling processor
//   with a one-cycle img_rdy strobe, then waits for pixel_done.
//
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   start      : frame start request, sampled in IDLE only
//   sw, sh     : source width/height in pixels (>= 1)
//   tw, th     : target width/height in pixels
//   x_step,
//   y_step     : Q8.8 source increment per target pixel
//   bus        : memory read port + window hand-off (scale_window_fetch_if.master)
//   busy       : high from start acceptance until frame end
//   frame_done : one-cycle pulse after the last window completes
module scale_window_fetch #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int FRAC = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [15:0]                 sw,
    input  logic [15:0]                 sh,
    input  logic [15:0]                 tw,
    input  logic [15:0]                 th,
    input  logic [15:0]                 x_step,
    input  logic [15:0]                 y_step,
    scale_window_fetch_if.master        bus,
    output logic                        busy,
    output logic                        frame_done
);

    typedef enum logic [3:0] {
        IDLE, CALC, RD0, RD1, RD2, RD3, CAP, ISSUE, WAIT_DONE, ADV
    } state_t;

    state_t state, state_nx;

    logic [15:0]   tx, ty;
    logic [15:0]   acc_x, acc_y;
    logic [15:0]   m, m1;
    logic [AW-1:0] base_n, base_n1;

    logic [15:0]   sw_max, sh_max;
    logic [15:0]   ix, iy;
    logic [15:0]   m_c, n_c, m1_c, n1_c;
    logic [31:0]   row_n, row_n1;
    logic          more_x, more_y;
    logic [DW-1:0] rdata;

    assign rdata = bus.mem_rdata;
    assign busy  = (state != IDLE);

    // Clamped source coordinates for the current accumulator values; only
    // registered in CALC, so the multipliers see stable operands there.
    always_comb begin
        sw_max = sw - 16'd1;
        sh_max = sh - 16'd1;
        ix     = acc_x >> FRAC;
        iy     = acc_y >> FRAC;
        m_c    = (ix > sw_max) ? sw_max : ix;
        n_c    = (iy > sh_max) ? sh_max : iy;
        m1_c   = (m_c < sw_max) ? m_c + 16'd1 : sw_max;
        n1_c   = (n_c < sh_max) ? n_c + 16'd1 : sh_max;
        row_n  = {16'd0, n_c}  * {16'd0, sw};
        row_n1 = {16'd0, n1_c} * {16'd0, sw};
        more_x = (tx < tw - 16'd1);
        more_y = (ty < th - 16'd1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = '0;
        bus.img_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (tw != '0) && (th != '0)) begin
                    state_nx = CALC;
                end
            end
            CALC: state_nx = RD0;
            RD0: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = base_n + AW'(m);
                state_nx      = RD1;
            end
            RD1: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = base_n + AW'(m1);
                state_nx      = RD2;
            end
            RD2: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = base_n1 + AW'(m);
                state_nx      = RD3;
            end
            RD3: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = base_n1 + AW'(m1);
                state_nx      = CAP;
            end
            CAP: state_nx = ISSUE;
            ISSUE: begin
                bus.img_rdy = 1'b1;
                state_nx    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.pixel_done) begin
                    state_nx = ADV;
                end
            end
            ADV: state_nx = (more_x || more_y) ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data arrives one cycle after each RDx, so each pixel register
    // is loaded in the state following its read (RD1..RD3, CAP).
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx          <= '0;
            ty          <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            m           <= '0;
            m1          <= '0;
            base_n      <= '0;
            base_n1     <= '0;
            bus.imgmn   <= '0;
            bus.imgm1n  <= '0;
            bus.imgmn1  <= '0;
            bus.imgm1n1 <= '0;
            bus.loc_x   <= '0;
            bus.loc_y   <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx    <= '0;
                        ty    <= '0;
                        acc_x <= '0;
                        acc_y <= '0;
                        if ((tw == '0) || (th == '0)) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    m       <= m_c;
                    m1      <= m1_c;
                    base_n  <= AW'(row_n);
                    base_n1 <= AW'(row_n1);
                end
                RD1: bus.imgmn  <= rdata;
                RD2: bus.imgm1n <= rdata;
                RD3: bus.imgmn1 <= rdata;
                CAP: begin
                    bus.imgm1n1 <= rdata;
                    bus.loc_x   <= acc_x;
                    bus.loc_y   <= acc_y;
                end
                ADV: begin
                    if (more_x) begin
                        tx    <= tx + 16'd1;
                        acc_x <= acc_x + x_step;
                    end else if (more_y) begin
                        tx    <= '0;
                        acc_x <= '0;
                        ty    <= ty + 16'd1;
                        acc_y <= acc_y + y_step;
                    end else begin
                        frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scale_window_fetch.sv
// tb_scale_window_fetch
//   Self-checking bench for scale_window_fetch. A source memory model answers
//   reads one cycle late; expected windows are computed per frame from the
//   target->source mapping (loc = index * step mod 2^16, clamped 2x2 fetch).
module tb_scale_window_fetch;

    localparam int DW = 16;
    localparam int AW = 16;

    typedef struct packed {
        logic [3:0][15:0] addr;
        logic [3:0][15:0] pix;
        logic [15:0]      lx;
        logic [15:0]      ly;
    } win_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_req = 1'b0;
    logic        start_spam = 1'b0;
    logic        start;
    logic [15:0] sw = 16'd2, sh = 16'd2, tw = 16'd2, th = 16'd2;
    logic [15:0] x_step = 16'h0100, y_step = 16'h0100;
    logic        busy, frame_done;
    logic        pd_auto = 1'b0, pd_manual = 1'b0;

    logic        auto_done = 1'b0;
    logic        spam_en = 1'b0, spur_en = 1'b0;
    int unsigned max_dly = 0;
    int unsigned dly;

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned rdy_count = 0, fd_count = 0;

    logic [15:0] mem [0:1023];
    win_t        exp_q[$];
    logic [15:0] got_addr[$];
    logic        rd_pend = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    scale_window_fetch_if #(.DW(DW), .AW(AW)) bus();

    assign start          = start_req | start_spam;
    assign bus.pixel_done = pd_auto | pd_manual;

    scale_window_fetch #(.DW(DW), .AW(AW), .FRAC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sw        (sw),
        .sh        (sh),
        .tw        (tw),
        .th        (th),
        .x_step    (x_step),
        .y_step    (y_step),
        .bus       (bus),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Source memory: data valid one cycle after the read strobe.
    always @(negedge clk) begin
        rd_pend = bus.mem_rd_en;
        rd_addr = bus.mem_addr;
    end
    always @(posedge clk) begin
        if (rd_pend) begin
            #1 bus.mem_rdata = mem[rd_addr[9:0]];
        end
    end

    // Processor model: pixel_done after a random wait, optional stray
    // pixel_done in ISSUE and stray start pulses in ISSUE/WAIT_DONE.
    always begin
        @(negedge clk);
        if (auto_done && bus.img_rdy) begin
            dly = $urandom_range(0, max_dly);
            if (spam_en) start_spam = 1'($urandom_range(0, 1));
            if (spur_en) pd_auto = 1'($urandom_range(0, 1));
            for (int unsigned j = 1; j <= dly + 1; j++) begin
                @(negedge clk);
                if (j >= 2) start_spam = 1'b0;
                pd_auto = (j == dly + 1);
            end
            @(negedge clk);
            pd_auto    = 1'b0;
            start_spam = 1'b0;
        end
    end

    // Window monitor against the expected queue.
    always @(negedge clk) begin
        win_t w;
        if (bus.mem_rd_en) got_addr.push_back(bus.mem_addr);
        if (bus.img_rdy) begin
            rdy_count++;
            if (exp_q.size() == 0) begin
                check("extra_window", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("imgmn",   bus.imgmn,   w.pix[0]);
                check("imgm1n",  bus.imgm1n,  w.pix[1]);
                check("imgmn1",  bus.imgmn1,  w.pix[2]);
                check("imgm1n1", bus.imgm1n1, w.pix[3]);
                check("loc_x",   bus.loc_x,   w.lx);
                check("loc_y",   bus.loc_y,   w.ly);
                check("reads_per_window", got_addr.size(), 4);
                for (int unsigned i = 0; i < 4; i++) begin
                    if (i < got_addr.size()) check("addr", got_addr[i], w.addr[i]);
                end
            end
            got_addr.delete();
        end
        if (frame_done) begin
            fd_count++;
            check("busy_at_frame_done", busy, 0);
        end
    end

    task automatic build_frame();
        win_t w;
        int   sws, shs, ax, ay, mm, nn, mm1, nn1;
        exp_q.delete();
        got_addr.delete();
        sws = int'(sw);
        shs = int'(sh);
        for (int unsigned y = 0; y < th; y++) begin
            for (int unsigned x = 0; x < tw; x++) begin
                ax  = int'((x * x_step) & 32'hFFFF);
                ay  = int'((y * y_step) & 32'hFFFF);
                mm  = (ax >> 8) > sws - 1 ? sws - 1 : (ax >> 8);
                nn  = (ay >> 8) > shs - 1 ? shs - 1 : (ay >> 8);
                mm1 = mm + 1 > sws - 1 ? sws - 1 : mm + 1;
                nn1 = nn + 1 > shs - 1 ? shs - 1 : nn + 1;
                w.addr[0] = 16'(nn * sws + mm);
                w.addr[1] = 16'(nn * sws + mm1);
                w.addr[2] = 16'(nn1 * sws + mm);
                w.addr[3] = 16'(nn1 * sws + mm1);
                for (int unsigned i = 0; i < 4; i++) w.pix[i] = mem[w.addr[i][9:0]];
                w.lx = 16'(ax);
                w.ly = 16'(ay);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},      bus.mem_rd_en, 0);
        check({tag, "_addr"},       bus.mem_addr, 0);
        check({tag, "_pixels"},     {bus.imgmn, bus.imgm1n, bus.imgmn1, bus.imgm1n1} == '0, 1);
        check({tag, "_loc"},        {bus.loc_x, bus.loc_y}, 0);
        check({tag, "_img_rdy"},    bus.img_rdy, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Pulse start for one edge and measure cycles to the first img_rdy.
    task automatic start_frame();
        int unsigned lat;
        rdy_count = 0;
        fd_count  = 0;
        @(negedge clk);
        start_req = 1'b1;
        @(posedge clk);
        #1 start_req = 1'b0;
        lat = 0;
        while (!bus.img_rdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("start_to_img_rdy", lat, 7);
    endtask

    task automatic wait_end();
        int unsigned cyc, budget;
        budget = int'(tw) * int'(th) * (12 + max_dly) + 50;
        cyc = 0;
        while (fd_count == 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= budget) check("frame_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("frame_done_count", fd_count, 1);
        check("window_count", rdy_count, int'(tw) * int'(th));
        check("windows_left", exp_q.size(), 0);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic run_frame();
        build_frame();
        start_frame();
        wait_end();
    endtask

    initial begin
        int unsigned lat, any_rd, any_rdy, any_busy;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Directed 2x2 source, 2x2 target, unit steps
        mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30; mem[3] = 16'd40;
        sw = 2; sh = 2; tw = 2; th = 2; x_step = 16'h0100; y_step = 16'h0100;
        auto_done = 1'b1; max_dly = 0;
        run_frame();

        // Upscale 2x2 -> 4x4
        tw = 4; th = 4; x_step = 16'h0080; y_step = 16'h0080;
        run_frame();

        // Latency and hold with pixel_done withheld
        tw = 2; th = 2; x_step = 16'h0100; y_step = 16'h0100;
        auto_done = 1'b0;
        build_frame();
        start_frame();
        any_rd = 0; any_rdy = 0;
        repeat (20) begin
            @(negedge clk);
            any_rd  |= bus.mem_rd_en;
            any_rdy |= bus.img_rdy;
        end
        check("hold_no_reads", any_rd, 0);
        check("hold_no_rdy", any_rdy, 0);
        check("hold_imgmn", bus.imgmn, 10);
        check("hold_imgm1n", bus.imgm1n, 20);
        check("hold_imgmn1", bus.imgmn1, 30);
        check("hold_imgm1n1", bus.imgm1n1, 40);
        check("hold_busy", busy, 1);
        pd_manual = 1'b1;
        @(posedge clk);
        #1 pd_manual = 1'b0;
        auto_done = 1'b1;
        lat = 0;
        while (!bus.img_rdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("done_to_next_rdy", lat, 8);
        wait_end();

        // Empty target: immediate frame_done, no activity
        for (int unsigned k = 0; k < 2; k++) begin
            tw = (k == 0) ? 16'd0 : 16'd3;
            th = (k == 0) ? 16'd3 : 16'd0;
            fd_count = 0;
            @(negedge clk);
            start_req = 1'b1;
            @(posedge clk);
            #1 start_req = 1'b0;
            @(negedge clk);
            check("empty_frame_done", frame_done, 1);
            any_rd = 0; any_busy = 0;
            repeat (5) begin
                any_rd   |= bus.mem_rd_en;
                any_busy |= busy;
                @(negedge clk);
            end
            check("empty_no_reads", any_rd, 0);
            check("empty_no_busy", any_busy, 0);
            check("empty_frame_done_count", fd_count, 1);
        end

        // Reset during RD2, then a fresh frame
        sw = 3; sh = 3; tw = 3; th = 3; x_step = 16'h00C0; y_step = 16'h00A0;
        for (int unsigned i = 0; i < 9; i++) mem[i] = 16'($urandom);
        build_frame();
        @(negedge clk);
        start_req = 1'b1;
        @(posedge clk);
        #1 start_req = 1'b0;
        repeat (4) @(negedge clk);
        check("rd2_rd_en", bus.mem_rd_en, 1);
        check("rd2_addr", bus.mem_addr, exp_q[0].addr[2]);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b1;
        run_frame();

        // Randomised frames with stray start/pixel_done and random waits
        spam_en = 1'b1; spur_en = 1'b1; max_dly = 3;
        for (int unsigned f = 0; f < 10; f++) begin
            sw = 16'($urandom_range(1, 12));
            sh = 16'($urandom_range(1, 12));
            tw = 16'($urandom_range(1, 6));
            th = 16'($urandom_range(1, 6));
            for (int unsigned i = 0; i < 144; i++) mem[i] = 16'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    x_step = 16'((int'(sw) << 8) / int'(tw));
                    y_step = 16'((int'(sh) << 8) / int'(th));
                end
                1: begin
                    x_step = 16'($urandom);
                    y_step = 16'($urandom);
                end
                default: begin
                    x_step = 16'((int'(sw) << 8) / int'(tw) + $urandom_range(0, 64));
                    y_step = 16'((int'(sh) << 8) / int'(th) + $urandom_range(0, 64));
                end
            endcase
            run_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
